// File: rtl/fft_8_input_buffer.sv
// Double-buffered 8-point complex frame collector feeding an 8-point FFT core.
// One bank fills from the sample stream while the other is held stable for the core.
module fft_8_input_buffer #(
  parameter int DATA_W = 16,
  parameter bit BITREV = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_W-1:0]     in_real,
  input  logic [DATA_W-1:0]     in_imag,
  input  logic                  in_last,
  output logic                  fft_start,
  input  logic                  fft_done,
  output logic [8*DATA_W-1:0]   fft_real,
  output logic [8*DATA_W-1:0]   fft_imag,
  output logic                  frame_err,
  output logic [7:0]            frame_count
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  function automatic logic [2:0] wr_pos(input logic [2:0] k);
    if (BITREV) begin
      wr_pos = {k[0], k[1], k[2]};
    end else begin
      wr_pos = k;
    end
  endfunction

  logic [1:0][7:0][DATA_W-1:0] re_q, im_q;
  logic [1:0]  full_q, full_d;
  logic        wr_sel_q, wr_sel_d;
  logic        rd_sel_q, rd_sel_d;
  logic [2:0]  idx_q, idx_d;
  logic        started_q;
  state_e      state_q, state_d;
  logic        fft_start_q, fft_start_d;
  logic        frame_err_q, frame_err_d;
  logic [7:0]  frame_count_q, frame_count_d;

  logic hs_s, last_k_s, abort_s, store_s, complete_s, release_s;

  assign in_ready   = started_q & ~full_q[wr_sel_q];
  assign hs_s       = in_valid & in_ready;
  assign last_k_s   = (idx_q == 3'd7);
  assign abort_s    = hs_s & in_last & ~last_k_s;
  assign store_s    = hs_s & ~abort_s;
  assign complete_s = hs_s & last_k_s;
  // The start cycle is excluded so a stale done cannot release the bank just issued.
  assign release_s  = (state_q == ST_BUSY) & fft_done & ~fft_start_q;

  // Fill side: write index, bank fill flags and bank selectors.
  always_comb begin
    idx_d       = idx_q;
    wr_sel_d    = wr_sel_q;
    rd_sel_d    = rd_sel_q;
    full_d      = full_q;
    frame_err_d = 1'b0;
    if (abort_s) begin
      idx_d       = 3'd0;
      frame_err_d = 1'b1;
    end else if (complete_s) begin
      idx_d            = 3'd0;
      full_d[wr_sel_q] = 1'b1;
      wr_sel_d         = ~wr_sel_q;
      frame_err_d      = ~in_last;
    end else if (store_s) begin
      idx_d = idx_q + 3'd1;
    end else begin
      idx_d = idx_q;
    end
    // Release and completion always touch different banks, so both may apply.
    if (release_s) begin
      full_d[rd_sel_q] = 1'b0;
      rd_sel_d         = ~rd_sel_q;
    end else begin
      rd_sel_d = rd_sel_q;
    end
  end

  // Drain FSM: issue a start as soon as the presented bank becomes full.
  always_comb begin
    state_d       = state_q;
    fft_start_d   = 1'b0;
    frame_count_d = frame_count_q;
    case (state_q)
      ST_IDLE: begin
        if (full_d[rd_sel_q]) begin
          state_d       = ST_BUSY;
          fft_start_d   = 1'b1;
          frame_count_d = frame_count_q + 8'd1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (release_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_BUSY;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Control and status registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      started_q     <= 1'b0;
      idx_q         <= 3'd0;
      wr_sel_q      <= 1'b0;
      rd_sel_q      <= 1'b0;
      full_q        <= 2'b00;
      state_q       <= ST_IDLE;
      fft_start_q   <= 1'b0;
      frame_err_q   <= 1'b0;
      frame_count_q <= 8'd0;
    end else begin
      started_q     <= 1'b1;
      idx_q         <= idx_d;
      wr_sel_q      <= wr_sel_d;
      rd_sel_q      <= rd_sel_d;
      full_q        <= full_d;
      state_q       <= state_d;
      fft_start_q   <= fft_start_d;
      frame_err_q   <= frame_err_d;
      frame_count_q <= frame_count_d;
    end
  end

  // Sample storage; the presented bank is never written while it is full.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      re_q <= '0;
      im_q <= '0;
    end else if (store_s) begin
      re_q[wr_sel_q][wr_pos(idx_q)] <= in_real;
      im_q[wr_sel_q][wr_pos(idx_q)] <= in_imag;
    end else begin
      re_q <= re_q;
      im_q <= im_q;
    end
  end

  assign fft_real    = re_q[rd_sel_q];
  assign fft_imag    = im_q[rd_sel_q];
  assign fft_start   = fft_start_q;
  assign frame_err   = frame_err_q;
  assign frame_count = frame_count_q;

endmodule
